// File: rtl/frame_stream.sv
// rtl/frame_stream.sv - frame BRAM to FFT AXI-stream streamer with hop, drop and tlast-error accounting; optional macro BARTLETT_WINDOW_EN
module frame_stream #(
    parameter int ADDR_W   = 12,
    parameter int SAMPLE_W = 14,
    parameter int CPLX_W   = 16,
    parameter int HOP_LOG2 = 0,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     head,
    input  logic                  start,
    output logic [ADDR_W-1:0]     addr,
    input  logic [SAMPLE_W-1:0]   data,
    output logic [2*CPLX_W-1:0]   frame_tdata,
    output logic                  frame_tvalid,
    input  logic                  frame_tready,
    output logic                  frame_tlast,
    input  logic                  last_missing,
    output logic                  busy,
    output logic                  frame_dropped,
    output logic [CNT_W-1:0]      drop_count,
    output logic [CNT_W-1:0]      tlast_err_count
);

    localparam int N     = 1 << ADDR_W;
    localparam int HOP_W = (HOP_LOG2 > 0) ? HOP_LOG2 : 1;
`ifdef BARTLETT_WINDOW_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif
    localparam logic [ADDR_W:0] K_LAST = (ADDR_W+1)'(N - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                 state, state_nxt;
    logic [HOP_W-1:0]       hop_cnt;
    logic                   trigger;
    logic [ADDR_W-1:0]      base;
    logic [ADDR_W:0]        k;
    logic                   issue;
    logic                   pop;
    logic                   push;
    logic                   rd_pend;
    logic                   rd_pend_last;
    logic [1:0]             inflight;
    logic [2:0]             occ;
    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [CPLX_W-1:0]   push_real;
    logic                   push_last;

    // Four physical slots with free-running 2-bit pointers; occupancy is
    // capped at DEPTH by the issue rule, so the pointers never collide.
    logic [CPLX_W:0]        fifo_mem [4];
    logic [1:0]             rd_ptr, wr_ptr, count;
    logic [CPLX_W:0]        head_word;

`ifdef BARTLETT_WINDOW_EN
    logic [ADDR_W-1:0]              rd_pend_k;
    logic [ADDR_W-1:0]              w_fold;
    logic [ADDR_W-1:0]              win;
    logic signed [SAMPLE_W+ADDR_W:0] win_prod;
    logic signed [SAMPLE_W+ADDR_W:0] win_shift;
    logic                           s2_valid;
    logic                           s2_last;
    logic signed [CPLX_W-1:0]       s2_real;
`endif

    // Launch qualifier: every start when HOP_LOG2 is 0, else the last start of each hop.
    always_comb begin
        trigger = start && ((HOP_LOG2 == 0) || (&hop_cnt));
    end

    // Hop counter, free-running modulo 2^HOP_LOG2 on start pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hop_cnt <= '0;
        end else if (start && (HOP_LOG2 != 0)) begin
            hop_cnt <= hop_cnt + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: launch on trigger, return to idle when the tlast word is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (trigger) state_nxt = S_STREAM;
            S_STREAM: if (pop && frame_tlast) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Read issue: keep reads in flight plus buffered words (after this cycle's pop) below DEPTH.
    always_comb begin
`ifdef BARTLETT_WINDOW_EN
        inflight = {1'b0, rd_pend} + {1'b0, s2_valid};
`else
        inflight = {1'b0, rd_pend};
`endif
        pop   = frame_tvalid && frame_tready;
        occ   = {1'b0, inflight} + {1'b0, count} - {2'b00, pop};
        issue = (state == S_STREAM) && !k[ADDR_W] && (occ < 3'(DEPTH));
        addr  = base + k[ADDR_W-1:0];
    end

    // Frame base/index and the one-cycle BRAM read pipeline tag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base         <= '0;
            k            <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= issue && (k == K_LAST);
            if ((state == S_IDLE) && trigger) begin
                // head has just advanced with this write, so head+1 is the oldest sample.
                base <= head + 1'b1;
                k    <= '0;
            end else if (issue) begin
                k <= k + 1'b1;
            end
        end
    end

    // Offset-binary to two's complement: flipping the MSB recentres the sample at zero.
    always_comb begin
        sample_s = {~data[SAMPLE_W-1], data[SAMPLE_W-2:0]};
`ifdef BARTLETT_WINDOW_EN
        w_fold    = rd_pend_k[ADDR_W-1] ? ~rd_pend_k : rd_pend_k;
        win       = {w_fold[ADDR_W-2:0], 1'b0};
        win_prod  = sample_s * $signed({1'b0, win});
        win_shift = win_prod >>> ADDR_W;
        push      = s2_valid;
        push_real = s2_real;
        push_last = s2_last;
`else
        push      = rd_pend;
        push_real = CPLX_W'(sample_s);
        push_last = rd_pend_last;
`endif
    end

`ifdef BARTLETT_WINDOW_EN
    // Window stage: hold the sample index alongside the read, then register the weighted sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend_k <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_real   <= '0;
        end else begin
            if (issue) rd_pend_k <= k[ADDR_W-1:0];
            s2_valid <= rd_pend;
            s2_last  <= rd_pend_last;
            s2_real  <= CPLX_W'(win_shift);
        end
    end
`endif

    // Skid buffer storage; entries are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {push_last, push_real};
    end

    // Skid buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Stream outputs come straight from the buffer head, so they hold while stalled.
    always_comb begin
        head_word    = fifo_mem[rd_ptr];
        frame_tvalid = (count != 2'd0);
        frame_tlast  = frame_tvalid && head_word[CPLX_W];
        frame_tdata  = frame_tvalid ? {{CPLX_W{1'b0}}, head_word[CPLX_W-1:0]} : '0;
        busy         = (state == S_STREAM);
    end

    // Drop and tlast-error accounting with saturating counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_dropped   <= 1'b0;
            drop_count      <= '0;
            tlast_err_count <= '0;
        end else begin
            frame_dropped <= trigger && (state != S_IDLE);
            if (trigger && (state != S_IDLE) && (drop_count != {CNT_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
            if (last_missing && (tlast_err_count != {CNT_W{1'b1}})) begin
                tlast_err_count <= tlast_err_count + 1'b1;
            end
        end
    end

endmodule
